// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the boot-ROM access arbiter: host ids,
// the response-pipeline slot and the byte-address legality check.
package rom_arb_pkg;

    localparam int unsigned MaxHosts = 4;
    localparam int unsigned HostIdW  = 2;

    typedef logic [HostIdW-1:0] host_id_t;

    typedef struct packed {
        logic     valid;
        host_id_t id;
        logic     err;
    } rsp_slot_t;

    // A byte address is readable only if it is word aligned and inside the ROM.
    function automatic logic rom_addr_legal(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational priority scan starting at a registered
// pointer, which advances to just past the most recent winner.
module rr_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned IdW = $clog2(N)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IdW-1:0] gnt_id,
    output logic           gnt_any
);

    logic [IdW-1:0] ptr;
    logic [IdW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = IdW'((int'(ptr) + i) % N);
            if (enable && !gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
        if (gnt_any) begin
            gnt[gnt_id] = 1'b1;
        end
    end

    // Wrap explicitly so non-power-of-two host counts stay in range.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == IdW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous single-port boot ROM between several requesters,
// checking each byte address and routing every response back to its issuer.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned NumHosts   = 2,
    parameter int unsigned Width      = 32,
    parameter int unsigned Depth      = 2048,
    parameter int unsigned Aw         = $clog2(Depth),
    parameter int unsigned RomLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumHosts-1:0]   req_i,
    input  logic [NumHosts*32-1:0] addr_i,
    output logic [NumHosts-1:0]   gnt_o,
    output logic [NumHosts-1:0]   rvalid_o,
    output logic [Width-1:0]      rdata_o,
    output logic                  err_o,
    output logic                  rom_cs_o,
    output logic [Aw-1:0]         rom_addr_o,
    input  logic [Width-1:0]      rom_rdata_i,
    input  logic                  rom_dvalid_i,
    output logic                  proto_err_o
);

    localparam int unsigned IdW = $clog2(NumHosts);

    logic [IdW-1:0] gnt_idx;
    logic           gnt_any;
    logic [31:0]    sel_addr;
    logic           addr_ok;
    rsp_slot_t      new_slot;
    rsp_slot_t      head;
    rsp_slot_t      pipe [RomLatency];
    logic           resp_live;
    logic           head_legal;

    rr_arbiter #(
        .N   (NumHosts),
        .IdW (IdW)
    ) u_arb (
        .clock   (clk_i),
        .reset   (rst_i),
        .enable  (~rst_i),
        .req     (req_i),
        .gnt     (gnt_o),
        .gnt_id  (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NumHosts; k++) begin
            if (gnt_idx == IdW'(k)) begin
                sel_addr = addr_i[32*k +: 32];
            end
        end
    end

    assign addr_ok    = rom_addr_legal(sel_addr, Depth);
    assign rom_cs_o   = gnt_any & addr_ok;
    assign rom_addr_o = rom_cs_o ? sel_addr[Aw+1:2] : '0;

    // Illegal accesses still take a slot so responses stay in grant order.
    always_comb begin
        new_slot       = '0;
        new_slot.valid = gnt_any;
        new_slot.id    = host_id_t'(gnt_idx);
        new_slot.err   = gnt_any & ~addr_ok;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RomLatency; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= new_slot;
            for (int i = 1; i < RomLatency; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign head       = pipe[RomLatency-1];
    assign resp_live  = head.valid & ~rst_i;
    assign head_legal = resp_live & ~head.err;

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < NumHosts; k++) begin
            rvalid_o[k] = resp_live && (head.id == host_id_t'(k));
        end
        err_o   = resp_live & head.err;
        rdata_o = head_legal ? rom_rdata_i : '0;
    end

    // The ROM strobe must track exactly the legal entries leaving the pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_o <= 1'b0;
        end else if (head_legal != rom_dvalid_i) begin
            proto_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench: three arbiters (RomLatency 1, 2, 3) share stimulus, each
// with its own behavioural ROM; index g of every array is latency g+1.
module tb_rom_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [2:0]  kill_dv;
    logic [2:0]  force_dv;

    logic [1:0]  gnt       [3];
    logic [1:0]  rvalid    [3];
    logic [31:0] rdata     [3];
    logic        err       [3];
    logic        cs        [3];
    logic [10:0] raddr     [3];
    logic [31:0] rom_rdata [3];
    logic        rom_dv    [3];
    logic        proto     [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [10:0] a);
        return (a == 11'd4) ? 32'hDEADBEEF : {16'hC0DE, 5'b00000, a};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] d [g+1];
        logic        v [g+1];

        rom_access_arbiter #(
            .NumHosts   (2),
            .Width      (32),
            .Depth      (2048),
            .RomLatency (g + 1)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req_i        (req),
            .addr_i       (addr),
            .gnt_o        (gnt[g]),
            .rvalid_o     (rvalid[g]),
            .rdata_o      (rdata[g]),
            .err_o        (err[g]),
            .rom_cs_o     (cs[g]),
            .rom_addr_o   (raddr[g]),
            .rom_rdata_i  (rom_rdata[g]),
            .rom_dvalid_i (rom_dv[g]),
            .proto_err_o  (proto[g])
        );

        always @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= g; i++) begin
                    d[i] <= '0;
                    v[i] <= 1'b0;
                end
            end else begin
                d[0] <= cs[g] ? rom_word(raddr[g]) : 32'h0;
                v[0] <= cs[g];
                for (int i = 1; i <= g; i++) begin
                    d[i] <= d[i-1];
                    v[i] <= v[i-1];
                end
            end
        end

        assign rom_rdata[g] = d[g];
        assign rom_dv[g]    = (v[g] & ~kill_dv[g]) | force_dv[g];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; addr = '0; kill_dv = '0; force_dv = '0;
        step(); step();
        #2;
        tests++;
        if (gnt[0] !== 2'b00) begin
            fails++; $display("[TB] FAIL reset_no_gnt: got %b expected 00", gnt[0]);
        end
        tests++;
        if (cs[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_cs: got %b expected 0", cs[0]);
        end
        rst = 1'b0; req = 2'b00;
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (rvalid[g] !== 2'b00 || rdata[g] !== 32'h0 || err[g] !== 1'b0 ||
                raddr[g] !== 11'h0 || proto[g] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_outputs[%0d]: got rvalid=%b rdata=%h err=%b raddr=%h proto=%b expected all zero",
                         g, rvalid[g], rdata[g], err[g], raddr[g], proto[g]);
            end
        end
        step();
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [10:0] prev_w;
        req = 2'b11; addr[31:0] = 32'h0; addr[63:32] = 32'h4;
        prev_g = 2'b00; prev_w = '0;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #2;
            tests++;
            if (gnt[0] !== exp_g || raddr[0] !== ((i % 2 == 0) ? 11'd0 : 11'd1)) begin
                fails++;
                $display("[TB] FAIL contention_gnt[%0d]: got gnt=%b raddr=%0d expected gnt=%b raddr=%0d",
                         i, gnt[0], raddr[0], exp_g, (i % 2));
            end
            tests++;
            if (i == 0) begin
                if (rvalid[0] !== 2'b00) begin
                    fails++; $display("[TB] FAIL contention_idle: got rvalid=%b expected 00", rvalid[0]);
                end
            end else if (rvalid[0] !== prev_g || rdata[0] !== rom_word(prev_w)) begin
                fails++;
                $display("[TB] FAIL contention_rsp[%0d]: got rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                         i, rvalid[0], rdata[0], prev_g, rom_word(prev_w));
            end
            prev_g = exp_g;
            prev_w = (i % 2 == 0) ? 11'd0 : 11'd1;
            step();
        end
        req = 2'b00;
        #2;
        tests++;
        if (rvalid[0] !== 2'b10 || rdata[0] !== rom_word(11'd1) || err[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL contention_last: got rvalid=%b rdata=%h err=%b expected 10 %h 0",
                     rvalid[0], rdata[0], err[0], rom_word(11'd1));
        end
        step();
    endtask

    task automatic test_single();
        req = 2'b01; addr[31:0] = 32'h0000_0010;
        #2;
        tests++;
        if (gnt[0] !== 2'b01 || cs[0] !== 1'b1 || raddr[0] !== 11'd4) begin
            fails++;
            $display("[TB] FAIL single_req: got gnt=%b cs=%b raddr=%0d expected 01 1 4", gnt[0], cs[0], raddr[0]);
        end
        step();
        req = 2'b00;
        #2;
        tests++;
        if (rvalid[0] !== 2'b01 || rdata[0] !== 32'hDEADBEEF || err[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_rsp: got rvalid=%b rdata=%h err=%b expected 01 deadbeef 0",
                     rvalid[0], rdata[0], err[0]);
        end
        step();
    endtask

    task automatic test_errors();
        logic [31:0] vec   [3];
        logic        legal [3];
        vec[0] = 32'h0000_2000; legal[0] = 1'b0;
        vec[1] = 32'h0000_0002; legal[1] = 1'b0;
        vec[2] = 32'h0000_1FFC; legal[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req = 2'b10; addr[63:32] = vec[i];
            #2;
            tests++;
            if (gnt[0] !== 2'b10 || cs[0] !== legal[i]) begin
                fails++;
                $display("[TB] FAIL err_req[%0d]: got gnt=%b cs=%b expected 10 %b", i, gnt[0], cs[0], legal[i]);
            end
            if (legal[i]) begin
                tests++;
                if (raddr[0] !== 11'd2047) begin
                    fails++; $display("[TB] FAIL err_last_word: got raddr=%0d expected 2047", raddr[0]);
                end
            end
            step();
            req = 2'b00;
            #2;
            tests++;
            if (rvalid[0] !== 2'b10 || err[0] !== ~legal[i] ||
                rdata[0] !== (legal[i] ? rom_word(11'd2047) : 32'h0)) begin
                fails++;
                $display("[TB] FAIL err_rsp[%0d]: got rvalid=%b err=%b rdata=%h expected 10 %b %h",
                         i, rvalid[0], err[0], rdata[0], ~legal[i], legal[i] ? rom_word(11'd2047) : 32'h0);
            end
            step();
        end
        tests++;
        if (proto[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL err_no_proto: got %b expected 0", proto[0]);
        end
    endtask

    task automatic test_latency3();
        req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        for (int c = 0; c < 10; c++) begin
            req = (c < 5) ? 2'b01 : 2'b00;
            addr[31:0] = 32'h20 + 32'(4 * c);
            #2;
            if (c < 5) begin
                tests++;
                if (gnt[2] !== 2'b01) begin
                    fails++; $display("[TB] FAIL lat3_gnt[%0d]: got %b expected 01", c, gnt[2]);
                end
            end
            tests++;
            if (c >= 3 && c < 8) begin
                if (rvalid[2] !== 2'b01 || rdata[2] !== rom_word(11'(c + 5)) || err[2] !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL lat3_rsp[%0d]: got rvalid=%b rdata=%h err=%b expected 01 %h 0",
                             c, rvalid[2], rdata[2], err[2], rom_word(11'(c + 5)));
                end
            end else if (rvalid[2] !== 2'b00) begin
                fails++; $display("[TB] FAIL lat3_idle[%0d]: got rvalid=%b expected 00", c, rvalid[2]);
            end
            step();
        end
        tests++;
        if (proto[2] !== 1'b0) begin
            fails++; $display("[TB] FAIL lat3_proto: got %b expected 0", proto[2]);
        end
    endtask

    task automatic test_reset_midflight();
        req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        req = 2'b01; addr[31:0] = 32'h8;
        #2;
        tests++;
        if (gnt[1] !== 2'b01) begin
            fails++; $display("[TB] FAIL mid_gnt: got %b expected 01", gnt[1]);
        end
        step();
        req = 2'b00; rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        tests++;
        if (rvalid[1] !== 2'b00 || rdata[1] !== 32'h0 || err[1] !== 1'b0 || proto[1] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_discard: got rvalid=%b rdata=%h err=%b proto=%b expected all zero",
                     rvalid[1], rdata[1], err[1], proto[1]);
        end
        req = 2'b11; addr[31:0] = 32'h0; addr[63:32] = 32'h4;
        #1;
        tests++;
        if (gnt[1] !== 2'b01) begin
            fails++; $display("[TB] FAIL mid_ptr_reset: got gnt=%b expected 01", gnt[1]);
        end
        step();
        req = 2'b00;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_protocol();
        req = 2'b01; addr[31:0] = 32'h0;
        #2;
        tests++;
        if (proto[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL proto_clean: got %b expected 0", proto[0]);
        end
        step();
        req = 2'b00; kill_dv = 3'b001;
        #2;
        tests++;
        if (rvalid[0] !== 2'b01 || proto[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL proto_due: got rvalid=%b proto=%b expected 01 0", rvalid[0], proto[0]);
        end
        step();
        kill_dv = 3'b000;
        #2;
        tests++;
        if (proto[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL proto_set: got %b expected 1", proto[0]);
        end
        step(); step();
        tests++;
        if (proto[0] !== 1'b1 || proto[2] !== 1'b0) begin
            fails++; $display("[TB] FAIL proto_hold: got lat1=%b lat3=%b expected 1 0", proto[0], proto[2]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        tests++;
        if (proto[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL proto_clear: got %b expected 0", proto[0]);
        end
        step();
        force_dv = 3'b010;
        #2;
        step();
        force_dv = 3'b000;
        #2;
        tests++;
        if (proto[1] !== 1'b1 || proto[0] !== 1'b0) begin
            fails++; $display("[TB] FAIL proto_spurious: got lat2=%b lat1=%b expected 1 0", proto[1], proto[0]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_errors();
        test_latency3();
        test_reset_midflight();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
